// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op encodings, ALU class codes and
// R-type funct codes used by the decode and execute stages.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    CLASS_ADD   = 2'b00,
    CLASS_SUB   = 2'b01,
    CLASS_RTYPE = 2'b10,
    CLASS_OR    = 2'b11
  } alu_class_e;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps the 2-bit ALU class and R-type funct onto a 4-bit
// ALU op; unknown R-type functs fall back to add and raise illegal.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (alu_class)
      CLASS_ADD: alu_op = ALU_ADD;
      CLASS_SUB: alu_op = ALU_SUB;
      CLASS_OR:  alu_op = ALU_OR;
      CLASS_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_NOR: alu_op = ALU_NOR;
          FUNCT_SLL: alu_op = ALU_SLL;
          default: begin
            alu_op  = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode at capture, stall/flush control
// and combinational EX/MEM and MEM/WB operand forwarding into the ALU.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_class,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_valid,
  output logic              ex_illegal,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch
);

  logic [3:0]        dec_op;
  logic              dec_illegal;
  logic              dec_sll;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic              alu_src_q;
  logic              sll_q;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_class (id_alu_class),
    .funct     (id_funct),
    .alu_op    (dec_op),
    .illegal   (dec_illegal)
  );

  assign dec_sll = (id_alu_class == CLASS_RTYPE) && (id_funct == FUNCT_SLL);

  // A bubble (flush, or capture with id_valid low) clears every control bit so
  // nothing downstream is written; its data fields are simply don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc4        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      ex_dst        <= '0;
      alu_op        <= '0;
      alu_src_q     <= 1'b0;
      sll_q         <= 1'b0;
      ex_valid      <= 1'b0;
      ex_illegal    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
    end else if (flush) begin
      alu_op        <= ALU_ADD;
      alu_src_q     <= 1'b0;
      sll_q         <= 1'b0;
      ex_valid      <= 1'b0;
      ex_illegal    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
    end else if (!stall) begin
      ex_pc4        <= id_pc4;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      imm_q         <= id_imm;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      ex_dst        <= id_reg_dst ? id_rd : id_rt;
      alu_op        <= id_valid ? dec_op : ALU_ADD;
      alu_src_q     <= id_valid & id_alu_src;
      sll_q         <= id_valid & dec_sll;
      ex_valid      <= id_valid;
      ex_illegal    <= id_valid & dec_illegal;
      ex_reg_write  <= id_valid & id_reg_write;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      ex_branch     <= id_valid & id_branch;
    end
  end

  // EX/MEM is the younger producer so it wins over MEM/WB; $zero never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;

    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end

  assign alu_in1       = sll_q ? fwd_rt : fwd_rs;
  assign alu_in2       = sll_q ? '0 : (alu_src_q ? imm_q : fwd_rt);
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each directed vector pushes its expected
// EX-side outputs, and a negedge monitor pops and compares them one cycle later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        rstN;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  cls;
    logic        aluSrc;
    logic        regDst;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        branch;
    logic        exWe;
    logic [4:0]  exRd;
    logic [31:0] exRes;
    logic        wbWe;
    logic [4:0]  wbRd;
    logic [31:0] wbRes;
  } stim_t;

  typedef struct packed {
    logic        doData;
    logic        valid;
    logic        illegal;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        branch;
    logic [3:0]  aluOp;
    logic [4:0]  dst;
    logic [31:0] pc4;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_class;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_branch;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dst;
  logic [31:0] ex_pc4;
  logic        ex_valid;
  logic        ex_illegal;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_pc4          (id_pc4),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_funct        (id_funct),
    .id_alu_class    (id_alu_class),
    .id_alu_src      (id_alu_src),
    .id_reg_dst      (id_reg_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_mem_to_reg   (id_mem_to_reg),
    .id_branch       (id_branch),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .alu_in1         (alu_in1),
    .alu_in2         (alu_in2),
    .alu_op          (alu_op),
    .ex_store_data   (ex_store_data),
    .ex_dst          (ex_dst),
    .ex_pc4          (ex_pc4),
    .ex_valid        (ex_valid),
    .ex_illegal      (ex_illegal),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_branch       (ex_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim();
    stim_t s;
    s       = '0;
    s.rstN  = 1'b1;
    s.valid = 1'b1;
    return s;
  endfunction

  function automatic exp_t mkExp();
    exp_t e;
    e        = '0;
    e.doData = 1'b1;
    return e;
  endfunction

  function automatic exp_t bubbleExp();
    exp_t e;
    e       = '0;
    e.aluOp = 4'b0010;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one vector shortly after a negedge; its expectation is checked at the next negedge.
  task automatic applyStimulus(input stim_t s, input exp_t e);
    rst_n           = s.rstN;
    stall           = s.stall;
    flush           = s.flush;
    id_valid        = s.valid;
    id_pc4          = s.pc4;
    id_rs_data      = s.rsData;
    id_rt_data      = s.rtData;
    id_imm          = s.imm;
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_rd           = s.rd;
    id_funct        = s.funct;
    id_alu_class    = s.cls;
    id_alu_src      = s.aluSrc;
    id_reg_dst      = s.regDst;
    id_reg_write    = s.regWrite;
    id_mem_read     = s.memRead;
    id_mem_write    = s.memWrite;
    id_mem_to_reg   = s.memToReg;
    id_branch       = s.branch;
    exmem_reg_write = s.exWe;
    exmem_rd        = s.exRd;
    exmem_result    = s.exRes;
    memwb_reg_write = s.wbWe;
    memwb_rd        = s.wbRd;
    memwb_result    = s.wbRes;
    expQ.push_back(e);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("ex_valid",      {31'b0, ex_valid},      {31'b0, e.valid});
      checkOutput("ex_illegal",    {31'b0, ex_illegal},    {31'b0, e.illegal});
      checkOutput("ex_reg_write",  {31'b0, ex_reg_write},  {31'b0, e.regWrite});
      checkOutput("ex_mem_read",   {31'b0, ex_mem_read},   {31'b0, e.memRead});
      checkOutput("ex_mem_write",  {31'b0, ex_mem_write},  {31'b0, e.memWrite});
      checkOutput("ex_mem_to_reg", {31'b0, ex_mem_to_reg}, {31'b0, e.memToReg});
      checkOutput("ex_branch",     {31'b0, ex_branch},     {31'b0, e.branch});
      checkOutput("alu_op",        {28'b0, alu_op},        {28'b0, e.aluOp});
      if (e.doData) begin
        checkOutput("ex_dst",        {27'b0, ex_dst}, {27'b0, e.dst});
        checkOutput("ex_pc4",        ex_pc4,          e.pc4);
        checkOutput("alu_in1",       alu_in1,         e.in1);
        checkOutput("alu_in2",       alu_in2,         e.in2);
        checkOutput("ex_store_data", ex_store_data,   e.store);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    exp_t  heldExp;
    logic [5:0] rFunct [3];
    logic [3:0] rOp    [3];
    rFunct[0] = 6'b100100; rOp[0] = 4'b0000;
    rFunct[1] = 6'b100101; rOp[1] = 4'b0001;
    rFunct[2] = 6'b101010; rOp[2] = 4'b0111;

    // Reset held while ID presents an R-type add that writes a register
    s = mkStim();
    s.rstN = 1'b0; s.pc4 = 32'h100; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd3;
    s.rsData = 32'h11; s.rtData = 32'h22; s.funct = 6'b100000; s.cls = 2'b10;
    s.regDst = 1'b1; s.regWrite = 1'b1;
    applyStimulus(s, mkExp());

    s.rstN = 1'b1;
    e = mkExp();
    e.valid = 1'b1; e.regWrite = 1'b1; e.aluOp = 4'b0010; e.dst = 5'd3; e.pc4 = 32'h100;
    e.in1 = 32'h11; e.in2 = 32'h22; e.store = 32'h22;
    applyStimulus(s, e);

    // R-type sub
    s = mkStim();
    s.pc4 = 32'h104; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd4; s.rsData = 32'd10; s.rtData = 32'd3;
    s.funct = 6'b100010; s.cls = 2'b10; s.regDst = 1'b1; s.regWrite = 1'b1;
    e = mkExp();
    e.valid = 1'b1; e.regWrite = 1'b1; e.aluOp = 4'b0110; e.dst = 5'd4; e.pc4 = 32'h104;
    e.in1 = 32'd10; e.in2 = 32'd3; e.store = 32'd3;
    applyStimulus(s, e);

    // nor
    s.funct = 6'b100111; s.rsData = 32'hF0; s.rtData = 32'h0F;
    e.aluOp = 4'b1100; e.in1 = 32'hF0; e.in2 = 32'h0F; e.store = 32'h0F;
    applyStimulus(s, e);

    // unknown funct decodes as add and flags illegal
    s.funct = 6'b111111; s.rsData = 32'h1; s.rtData = 32'h2;
    e.aluOp = 4'b0010; e.illegal = 1'b1; e.in1 = 32'h1; e.in2 = 32'h2; e.store = 32'h2;
    applyStimulus(s, e);

    // and / or / slt
    for (int i = 0; i < 3; i++) begin
      s.funct = rFunct[i]; s.rsData = 32'h100 + i; s.rtData = 32'h200 + i;
      e.illegal = 1'b0; e.aluOp = rOp[i]; e.in1 = 32'h100 + i; e.in2 = 32'h200 + i; e.store = 32'h200 + i;
      applyStimulus(s, e);
    end

    // Forward priority: EX/MEM over MEM/WB
    s = mkStim();
    s.pc4 = 32'h110; s.rs = 5'd5; s.rt = 5'd6; s.rd = 5'd7; s.rsData = 32'h55; s.rtData = 32'h66;
    s.funct = 6'b100000; s.cls = 2'b10; s.regDst = 1'b1; s.regWrite = 1'b1;
    s.exWe = 1'b1; s.exRd = 5'd5; s.exRes = 32'hAA;
    s.wbWe = 1'b1; s.wbRd = 5'd5; s.wbRes = 32'hBB;
    e = mkExp();
    e.valid = 1'b1; e.regWrite = 1'b1; e.aluOp = 4'b0010; e.dst = 5'd7; e.pc4 = 32'h110;
    e.in1 = 32'hAA; e.in2 = 32'h66; e.store = 32'h66;
    applyStimulus(s, e);

    s.exWe = 1'b0;
    e.in1 = 32'hBB;
    applyStimulus(s, e);

    // Register 0 is never forwarded
    s.rs = 5'd0; s.exWe = 1'b1; s.exRd = 5'd0; s.wbRd = 5'd0;
    e.in1 = 32'h55;
    applyStimulus(s, e);

    // sw-style: immediate operand, rt forwarded from MEM/WB
    s = mkStim();
    s.pc4 = 32'h120; s.rs = 5'd2; s.rt = 5'd7; s.rsData = 32'h2000; s.rtData = 32'h77;
    s.imm = 32'hFFFFFFFC; s.cls = 2'b00; s.aluSrc = 1'b1; s.memWrite = 1'b1;
    s.exWe = 1'b1; s.exRd = 5'd8; s.exRes = 32'h999;
    s.wbWe = 1'b1; s.wbRd = 5'd7; s.wbRes = 32'h1234;
    e = mkExp();
    e.valid = 1'b1; e.memWrite = 1'b1; e.aluOp = 4'b0010; e.dst = 5'd7; e.pc4 = 32'h120;
    e.in1 = 32'h2000; e.in2 = 32'hFFFFFFFC; e.store = 32'h1234;
    applyStimulus(s, e);

    // stall and flush together: flush wins
    s.stall = 1'b1; s.flush = 1'b1; s.regWrite = 1'b1;
    applyStimulus(s, bubbleExp());

    // lw captured, then held for three stalled cycles while ID changes
    s = mkStim();
    s.pc4 = 32'h200; s.rs = 5'd3; s.rt = 5'd9; s.rsData = 32'h1000; s.rtData = 32'hDEAD;
    s.imm = 32'h8; s.cls = 2'b00; s.aluSrc = 1'b1; s.regWrite = 1'b1; s.memRead = 1'b1; s.memToReg = 1'b1;
    heldExp = mkExp();
    heldExp.valid = 1'b1; heldExp.regWrite = 1'b1; heldExp.memRead = 1'b1; heldExp.memToReg = 1'b1;
    heldExp.aluOp = 4'b0010; heldExp.dst = 5'd9; heldExp.pc4 = 32'h200;
    heldExp.in1 = 32'h1000; heldExp.in2 = 32'h8; heldExp.store = 32'hDEAD;
    applyStimulus(s, heldExp);

    for (int i = 0; i < 3; i++) begin
      s = mkStim();
      s.stall = 1'b1; s.pc4 = 32'h300 + 4 * i; s.rs = 5'd12; s.rt = 5'd13; s.rd = 5'd14;
      s.rsData = 32'h5000 + i; s.rtData = 32'h6000 + i; s.cls = 2'b10; s.funct = 6'b100010;
      s.regDst = 1'b1; s.memWrite = 1'b1; s.branch = 1'b1;
      applyStimulus(s, heldExp);
    end

    // sll: in1 takes rt, in2 forced to zero
    s = mkStim();
    s.pc4 = 32'h400; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd10; s.rsData = 32'h99; s.rtData = 32'h3;
    s.funct = 6'b000000; s.cls = 2'b10; s.regDst = 1'b1; s.regWrite = 1'b1;
    e = mkExp();
    e.valid = 1'b1; e.regWrite = 1'b1; e.aluOp = 4'b0100; e.dst = 5'd10; e.pc4 = 32'h400;
    e.in1 = 32'h3; e.in2 = 32'h0; e.store = 32'h3;
    applyStimulus(s, e);

    // beq
    s = mkStim();
    s.pc4 = 32'h404; s.rs = 5'd1; s.rt = 5'd2; s.rsData = 32'h5; s.rtData = 32'h5;
    s.cls = 2'b01; s.branch = 1'b1; s.funct = 6'b111111;
    e = mkExp();
    e.valid = 1'b1; e.branch = 1'b1; e.aluOp = 4'b0110; e.dst = 5'd2; e.pc4 = 32'h404;
    e.in1 = 32'h5; e.in2 = 32'h5; e.store = 32'h5;
    applyStimulus(s, e);

    // ori
    s = mkStim();
    s.pc4 = 32'h408; s.rs = 5'd4; s.rt = 5'd3; s.rsData = 32'h0F; s.rtData = 32'h33;
    s.imm = 32'hF0; s.cls = 2'b11; s.aluSrc = 1'b1; s.regWrite = 1'b1;
    e = mkExp();
    e.valid = 1'b1; e.regWrite = 1'b1; e.aluOp = 4'b0001; e.dst = 5'd3; e.pc4 = 32'h408;
    e.in1 = 32'h0F; e.in2 = 32'hF0; e.store = 32'h33;
    applyStimulus(s, e);

    // id_valid low captures a bubble, with no illegal flag
    s.valid = 1'b0; s.cls = 2'b10; s.funct = 6'b111111; s.memWrite = 1'b1; s.branch = 1'b1;
    applyStimulus(s, bubbleExp());

    // Reload ori, then assert reset asynchronously mid-instruction
    s = mkStim();
    s.pc4 = 32'h408; s.rs = 5'd4; s.rt = 5'd3; s.rsData = 32'h0F; s.rtData = 32'h33;
    s.imm = 32'hF0; s.cls = 2'b11; s.aluSrc = 1'b1; s.regWrite = 1'b1;
    applyStimulus(s, e);
    s.rstN = 1'b0;
    applyStimulus(s, mkExp());

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending required=0 pending", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
